// File: rtl/game_pkg.sv
// game_pkg: shared screen/sprite constants, plotter state encoding and job record
package game_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOR_W = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BIRD_W = 8;
  localparam int BIRD_H = 8;
  localparam int WALL_W = 16;
  localparam int GAP_H = 40;
  localparam logic [COLOR_W-1:0] BG_COLOR = 3'b000;
  localparam logic OBJ_WALL = 1'b0;
  localparam logic OBJ_BIRD = 1'b1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;
  typedef struct packed {
    logic obj;
    logic [X_W-1:0] nx;
    logic [X_W-1:0] ox;
    logic [Y_W-1:0] ny;
    logic [Y_W-1:0] oy;
    logic [COLOR_W-1:0] col;
  } job_t;
  function automatic logic [X_W-1:0] obj_w(input logic obj);
    return obj == OBJ_BIRD ? X_W'(BIRD_W) : X_W'(WALL_W);
  endfunction
  function automatic logic [Y_W-1:0] obj_h(input logic obj);
    return obj == OBJ_BIRD ? Y_W'(BIRD_H) : Y_W'(SCREEN_H);
  endfunction
endpackage

// File: rtl/sprite_plotter_if.sv
// sprite_plotter_if: draw-controller request and VGA pixel bus
interface sprite_plotter_if;
  import game_pkg::*;
  logic start;
  logic obj_sel;
  logic [X_W-1:0] new_x;
  logic [Y_W-1:0] new_y;
  logic [X_W-1:0] old_x;
  logic [Y_W-1:0] old_y;
  logic [COLOR_W-1:0] obj_color;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [COLOR_W-1:0] colour;
  logic plot;
  logic busy;
  logic done;
  modport master(output start, obj_sel, new_x, new_y, old_x, old_y, obj_color,
                 input x, y, colour, plot, busy, done);
  modport slave(input start, obj_sel, new_x, new_y, old_x, old_y, obj_color,
                output x, y, colour, plot, busy, done);
endinterface

// File: rtl/rect_scanner.sv
// rect_scanner: row-major cx/cy sweep of a width x height rectangle with last-pixel pulse
module rect_scanner
  import game_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           enable,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last
);
  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic row_end;
  always_comb begin
    row_end = cx_q == width - X_W'(1);
    last = enable && row_end && cy_q == height - Y_W'(1);
    cx_d = start ? '0 : enable ? (row_end ? '0 : cx_q + X_W'(1)) : cx_q;
    cy_d = start ? '0 : (enable && row_end) ? (last ? '0 : cy_q + Y_W'(1)) : cy_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end
  assign cx = cx_q;
  assign cy = cy_q;
endmodule

// File: rtl/sprite_plotter.sv
// sprite_plotter: erases an object's old rectangle then redraws it, one registered pixel per clock
module sprite_plotter
  import game_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  sprite_plotter_if.slave bus
);
  logic [1:0] state_q, state_d;
  job_t job_q, job_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [COLOR_W-1:0] colour_q, colour_d;
  logic plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [X_W-1:0] cx, x0;
  logic [Y_W-1:0] cy, y0;
  logic last, accept, erase, active, in_gap;
  logic [X_W:0] sx;
  logic [Y_W:0] sy, gap_end;
  always_comb begin
    accept = state_q == S_IDLE && bus.start;
    erase = state_q == S_ERASE;
    active = erase || state_q == S_DRAW;
    job_d = accept ? '{obj: bus.obj_sel, nx: bus.new_x, ox: bus.old_x, ny: bus.new_y,
                       oy: bus.old_y, col: bus.obj_color} : job_q;
    x0 = erase ? job_q.ox : job_q.nx;
    y0 = job_q.obj == OBJ_WALL ? '0 : (erase ? job_q.oy : job_q.ny);
    sx = {1'b0, x0} + {1'b0, cx};
    sy = {1'b0, y0} + {1'b0, cy};
    // widened so a gap touching the bottom edge does not wrap back to row 0
    gap_end = {1'b0, job_q.ny} + (Y_W+1)'(GAP_H);
    in_gap = job_q.obj == OBJ_WALL && sy >= {1'b0, job_q.ny} && sy < gap_end;
    state_d = accept ? S_ERASE
            : (active && last) ? (erase ? S_DRAW : S_FINISH)
            : state_q == S_FINISH ? S_IDLE : state_q;
    x_d = active ? sx[X_W-1:0] : x_q;
    y_d = active ? sy[Y_W-1:0] : y_q;
    colour_d = active ? ((erase || in_gap) ? BG_COLOR : job_q.col) : colour_q;
    plot_d = active && sx < (X_W+1)'(SCREEN_W) && sy < (Y_W+1)'(SCREEN_H);
    busy_d = active;
    done_d = state_q == S_FINISH;
  end
  rect_scanner u_scan (
    .clk    (clk),
    .resetn (resetn),
    .start  (accept),
    .enable (active),
    .width  (obj_w(job_q.obj)),
    .height (obj_h(job_q.obj)),
    .cx     (cx),
    .cy     (cy),
    .last   (last)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      job_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q <= job_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.x = x_q;
  assign bus.y = y_q;
  assign bus.colour = colour_q;
  assign bus.plot = plot_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: randomized and directed jobs checked pixel-by-pixel against a rectangle model
module tb_sprite_plotter;
  import game_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sprite_plotter_if bus();
  sprite_plotter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );
  task automatic drive(input logic obj, input int nx, input int ny, input int ox, input int oy,
                       input logic [2:0] col);
    bus.obj_sel = obj;
    bus.new_x = 8'(nx);
    bus.new_y = 7'(ny);
    bus.old_x = 8'(ox);
    bus.old_y = 7'(oy);
    bus.obj_color = col;
  endtask
  task automatic scramble();
    drive(1'($urandom), $urandom, $urandom, $urandom, $urandom, 3'($urandom));
  endtask
  task automatic run_job(input string name, input logic obj, input int nx, input int ny,
                         input int ox, input int oy, input logic [2:0] col, input int spur,
                         input bit tail);
    int w, h, n, idx, cx, cy, sx, sy;
    bit er;
    logic [2:0] ec;
    logic [20:0] exp_v, got_v;
    w = obj ? BIRD_W : WALL_W;
    h = obj ? BIRD_H : SCREEN_H;
    n = w * h;
    drive(obj, nx, ny, ox, oy, col);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    scramble();
    for (int k = 0; k < 2 * n; k++) begin
      idx = k % n;
      cx = idx % w;
      cy = idx / w;
      er = k < n;
      sx = (er ? ox : nx) + cx;
      sy = (obj ? (er ? oy : ny) : 0) + cy;
      ec = (er || (!obj && sy >= ny && sy < ny + GAP_H)) ? 3'b000 : col;
      exp_v = {sx < SCREEN_W && sy < SCREEN_H, 8'(sx), 7'(sy), ec, 1'b1, 1'b0};
      @(posedge clk);
      #1 got_v = {bus.plot, bus.x, bus.y, bus.colour, bus.busy, bus.done};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL %s pixel %0d {plot,x,y,col,busy,done} got=%h want=%h", name, k, got_v, exp_v);
      end
      if (k == spur) begin
        scramble();
        bus.start = 1'b1;
      end else if (k == spur + 1) bus.start = 1'b0;
    end
    @(posedge clk);
    #1 total++;
    if ({bus.done, bus.busy, bus.plot} !== 3'b100) begin
      bad++;
      $display("FAIL %s done {done,busy,plot} got=%b want=100", name, {bus.done, bus.busy, bus.plot});
    end
    if (tail) begin
      repeat (20) begin
        @(posedge clk);
        #1 total++;
        if ({bus.done, bus.busy, bus.plot} !== 3'b000) begin
          bad++;
          $display("FAIL %s idle {done,busy,plot} got=%b want=000", name, {bus.done, bus.busy, bus.plot});
        end
      end
    end
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 total++;
    if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done} !== 21'd0) begin
      bad++;
      $display("FAIL reset outputs got=%h want=0", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done});
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_bird_basic();
    run_job("bird_basic", 1'b1, 20, 33, 20, 30, 3'b110, -1, 1'b1);
  endtask
  task automatic test_wall_gap();
    run_job("wall_gap", 1'b0, 100, 50, 60, 20, 3'b010, -1, 1'b1);
  endtask
  task automatic test_right_clip();
    run_job("right_clip", 1'b0, 150, 90, 150, 10, 3'b101, -1, 1'b1);
  endtask
  task automatic test_busy_ignore();
    run_job("busy_ignore", 1'b1, 70, 60, 66, 58, 3'b011, 10, 1'b1);
  endtask
  task automatic test_reset_mid();
    drive(1'b0, 40, 30, 30, 30, 3'b111);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (WALL_W * SCREEN_H + 100) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    total++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid abort {plot,busy,done} got=%b want=000", {bus.plot, bus.busy, bus.done});
    end
    repeat (20) begin
      @(posedge clk);
      #1 total++;
      if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
        bad++;
        $display("FAIL reset_mid quiet {plot,busy,done} got=%b want=000", {bus.plot, bus.busy, bus.done});
      end
    end
    run_job("reset_mid_rerun", 1'b1, 12, 100, 5, 115, 3'b100, -1, 1'b1);
  endtask
  task automatic test_back_to_back();
    run_job("b2b_first", 1'b1, 158, 50, 150, 50, 3'b001, -1, 1'b0);
    run_job("b2b_second", 1'b1, 10, 118, 158, 50, 3'b111, -1, 1'b1);
  endtask
  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_job("rand_bird", 1'b1, $urandom_range(0, 170), $urandom_range(0, 127),
              $urandom_range(0, 170), $urandom_range(0, 127), 3'($urandom), -1, i[0]);
    for (int i = 0; i < 2; i++)
      run_job("rand_wall", 1'b0, $urandom_range(0, 170), $urandom_range(60, 127),
              $urandom_range(0, 170), $urandom_range(0, 127), 3'($urandom | 1), -1, 1'b1);
  endtask
  initial begin
    bus.start = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 3'b000);
    test_reset();
    test_bird_basic();
    test_wall_gap();
    test_right_clip();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
